// File: rtl/sdram_write.sv
// rtl/sdram_write.sv - SDRAM write-path initiator: ACTIVE, full-page WRITE burst, BURST STOP, PRECHARGE-all.
module sdram_write #(
  parameter int TRCD_CLK = 2,
  parameter int TWR_CLK  = 2,
  parameter int TRP_CLK  = 2
) (
  input  logic        wr_clk,
  input  logic        wr_rst_n,
  input  logic        init_end,
  input  logic        wr_en,
  input  logic [23:0] wr_addr_in,
  input  logic [9:0]  wr_burst_len,
  input  logic [15:0] wr_data_in,
  output logic        wr_ack,
  output logic        wr_end,
  output logic [3:0]  wr_cmd,
  output logic [1:0]  wr_bank,
  output logic [12:0] wr_addr,
  output logic        wr_sdram_en,
  output logic [15:0] wr_sdram_data
);

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_BST  = 4'b0110;
  localparam logic [3:0] CMD_PRE  = 4'b0010;

  typedef enum logic [3:0] {
    S_IDLE, S_ACT, S_TRCD, S_WRITE, S_DATA, S_TERM, S_TWR, S_PRE, S_TRP, S_END
  } state_t;

  state_t      state, state_nx;
  logic [9:0]  cnt, cnt_nx;
  logic [23:0] addr_q;
  logic [9:0]  len_q;
  logic [9:0]  eff_len;
  logic        grant;

  assign grant   = init_end && wr_en;
  // Zero means a single word; anything past a full page is clamped to the page size.
  assign eff_len = (wr_burst_len == 10'd0)   ? 10'd1   :
                   (wr_burst_len > 10'd512) ? 10'd512 : wr_burst_len;

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state         <= S_IDLE;
      cnt           <= 10'd0;
      addr_q        <= 24'd0;
      len_q         <= 10'd0;
      wr_sdram_data <= 16'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == S_IDLE && grant) begin
        addr_q <= wr_addr_in;
        len_q  <= eff_len;
      end
      if (wr_ack)
        wr_sdram_data <= wr_data_in;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt + 10'd1;
    wr_cmd      = CMD_NOP;
    wr_bank     = 2'b11;
    wr_addr     = 13'h1fff;
    wr_ack      = 1'b0;
    wr_end      = 1'b0;
    wr_sdram_en = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_nx = 10'd0;
        if (grant) state_nx = S_ACT;
      end
      S_ACT: begin
        wr_cmd   = CMD_ACT;
        wr_bank  = addr_q[23:22];
        wr_addr  = addr_q[21:9];
        cnt_nx   = 10'd0;
        state_nx = S_TRCD;
      end
      S_TRCD: begin
        // FIFO is read one cycle ahead so word 0 is registered onto DQ for the WRITE cycle.
        if (cnt == 10'(TRCD_CLK - 1)) begin
          wr_ack   = 1'b1;
          cnt_nx   = 10'd0;
          state_nx = S_WRITE;
        end
      end
      S_WRITE: begin
        wr_cmd      = CMD_WR;
        wr_bank     = addr_q[23:22];
        wr_addr     = {4'b0000, addr_q[8:0]};
        wr_sdram_en = 1'b1;
        wr_ack      = (len_q > 10'd1);
        cnt_nx      = 10'd0;
        state_nx    = (len_q == 10'd1) ? S_TERM : S_DATA;
      end
      S_DATA: begin
        wr_sdram_en = 1'b1;
        wr_ack      = (cnt + 10'd2 < len_q);
        if (cnt == len_q - 10'd2) begin
          cnt_nx   = 10'd0;
          state_nx = S_TERM;
        end
      end
      S_TERM: begin
        wr_cmd   = CMD_BST;
        cnt_nx   = 10'd0;
        state_nx = S_TWR;
      end
      S_TWR: begin
        if (cnt == 10'(TWR_CLK - 1)) begin
          cnt_nx   = 10'd0;
          state_nx = S_PRE;
        end
      end
      S_PRE: begin
        wr_cmd   = CMD_PRE;
        wr_bank  = addr_q[23:22];
        wr_addr  = 13'h0400;
        cnt_nx   = 10'd0;
        state_nx = S_TRP;
      end
      S_TRP: begin
        if (cnt == 10'(TRP_CLK - 1)) begin
          cnt_nx   = 10'd0;
          state_nx = S_END;
        end
      end
      S_END: begin
        wr_end   = 1'b1;
        cnt_nx   = 10'd0;
        state_nx = S_IDLE;
      end
      default: begin
        cnt_nx   = 10'd0;
        state_nx = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sdram_write.sv
// tb/tb_sdram_write.sv - scoreboard bench for sdram_write with a show-ahead FIFO model.
module tb_sdram_write;
  localparam int TRCD = 2;
  localparam int TWR  = 2;
  localparam int TRP  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_end;
  logic        wr_en;
  logic [23:0] wr_addr_in;
  logic [9:0]  wr_burst_len;
  logic [15:0] wr_data_in;
  logic        wr_ack;
  logic        wr_end;
  logic [3:0]  wr_cmd;
  logic [1:0]  wr_bank;
  logic [12:0] wr_addr;
  logic        wr_sdram_en;
  logic [15:0] wr_sdram_data;

  sdram_write #(.TRCD_CLK(TRCD), .TWR_CLK(TWR), .TRP_CLK(TRP)) dut (
    .wr_clk(clk), .wr_rst_n(rst_n), .init_end(init_end), .wr_en(wr_en),
    .wr_addr_in(wr_addr_in), .wr_burst_len(wr_burst_len), .wr_data_in(wr_data_in),
    .wr_ack(wr_ack), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_bank(wr_bank),
    .wr_addr(wr_addr), .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data)
  );

  always #5 clk = ~clk;

  logic [15:0] fifo_mem [2048];
  logic [10:0] rd_ptr;
  assign wr_data_in = fifo_mem[rd_ptr];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_ptr <= 11'd0;
    else if (wr_ack) rd_ptr <= rd_ptr + 11'd1;
  end

  typedef struct packed {
    logic [3:0]  cmd;
    logic        care_bank;
    logic [1:0]  bank;
    logic        care_addr;
    logic [12:0] addr;
    logic        en;
    logic [15:0] dq;
    logic        ack;
    logic        endp;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          base = 0;
  logic [15:0] prev_dq = 16'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, " cmd"},  32'(wr_cmd), 32'h7);
    check({tag, " bank"}, 32'(wr_bank), 32'h3);
    check({tag, " addr"}, 32'(wr_addr), 32'h1fff);
    check({tag, " ack"},  32'(wr_ack), 32'h0);
    check({tag, " end"},  32'(wr_end), 32'h0);
    check({tag, " en"},   32'(wr_sdram_en), 32'h0);
    check({tag, " dq"},   32'(wr_sdram_data), 32'h0);
  endtask

  // Starts at a negedge; checks every cycle from C1 through the IDLE cycle after END.
  task automatic do_burst(input string tag, input logic [23:0] a, input logic [9:0] len_in,
                          input int drop_at, input int abort_at);
    int   leff, w, term, pre, endc, k;
    exp_t e;
    leff = (len_in == 0) ? 1 : (len_in > 512) ? 512 : int'(len_in);
    w    = 2 + TRCD;
    term = w + leff;
    pre  = term + 1 + TWR;
    endc = pre + 1 + TRP;
    init_end = 1'b1; wr_en = 1'b1; wr_addr_in = a; wr_burst_len = len_in;
    for (int c = 1; c <= endc + 1; c++) begin
      e = '0;
      e.cmd = 4'b0111; e.bank = 2'b11; e.addr = 13'h1fff;
      if (c == 1) begin
        e.cmd = 4'b0011; e.care_bank = 1; e.bank = a[23:22]; e.care_addr = 1; e.addr = 13'(a[21:9]);
      end
      if (c == w)    begin e.cmd = 4'b0100; e.care_addr = 1; e.addr = {4'b0000, a[8:0]}; end
      if (c == term) e.cmd = 4'b0110;
      if (c == pre)  begin e.cmd = 4'b0010; e.care_addr = 1; e.addr = 13'h0400; end
      if (c == endc + 1) begin e.care_bank = 1; e.care_addr = 1; end
      e.en   = (c >= w && c < term);
      e.ack  = (c >= w - 1 && c <= w + leff - 2);
      e.endp = (c == endc);
      k = (c - w < leff - 1) ? c - w : leff - 1;
      e.dq = (c < w) ? prev_dq : fifo_mem[base + k];
      sb.push_back(e);
    end
    for (int c = 1; c <= endc + 1; c++) begin
      @(negedge clk);
      e = sb.pop_front();
      check($sformatf("%s C%0d cmd", tag, c), 32'(wr_cmd), 32'(e.cmd));
      if (e.care_bank) check($sformatf("%s C%0d bank", tag, c), 32'(wr_bank), 32'(e.bank));
      if (e.care_addr) check($sformatf("%s C%0d addr", tag, c), 32'(wr_addr), 32'(e.addr));
      check($sformatf("%s C%0d en", tag, c),  32'(wr_sdram_en), 32'(e.en));
      check($sformatf("%s C%0d dq", tag, c),  32'(wr_sdram_data), 32'(e.dq));
      check($sformatf("%s C%0d ack", tag, c), 32'(wr_ack), 32'(e.ack));
      check($sformatf("%s C%0d end", tag, c), 32'(wr_end), 32'(e.endp));
      if (c == drop_at) begin wr_en = 1'b0; wr_burst_len = 10'd9; end
      if (c == endc) wr_en = 1'b0;
      if (c == abort_at) begin
        rst_n = 1'b0;
        sb.delete();
        return;
      end
    end
    prev_dq = fifo_mem[base + leff - 1];
    base    = base + leff;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) fifo_mem[i] = 16'($urandom);
    rst_n = 1'b0; init_end = 1'b0; wr_en = 1'b0; wr_addr_in = '0; wr_burst_len = '0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;

    wr_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("noinit cmd",  32'(wr_cmd), 32'h7);
      check("noinit addr", 32'(wr_addr), 32'h1fff);
      check("noinit ack",  32'(wr_ack), 32'h0);
      check("noinit end",  32'(wr_end), 32'h0);
    end

    do_burst("len4",   {2'b01, 13'h0123, 9'h010}, 10'd4,   0, 0);
    do_burst("len1",   {2'b10, 13'h1abc, 9'h1ff}, 10'd1,   0, 0);
    do_burst("len0",   {2'b10, 13'h1abc, 9'h1ff}, 10'd0,   0, 0);
    do_burst("len600", {2'b11, 13'h0456, 9'h1f0}, 10'd600, 0, 0);
    do_burst("drop",   {2'b01, 13'h0123, 9'h010}, 10'd4,   5, 0);
    do_burst("abort",  {2'b00, 13'h0777, 9'h020}, 10'd8,   0, 7);
    @(negedge clk);
    check_reset("abort rst");
    prev_dq = 16'd0;
    base    = 0;
    rst_n   = 1'b1;
    do_burst("post",   {2'b10, 13'h0042, 9'h100}, 10'd3,   0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
